spmm_job_sched: RTL and testbench
=================================

Name: spmm_job_sched

Overview:
- Central sequencer for the SpMM tile engine. Owns the job lifecycle: RHS buffer load, LHS row issue to the N parallel PEs, PE-result capture into the output buffer, and output drain.
- Generates the four lhs_ready_* flavours (ns/ws/os/wos), rhs_ready and out_ready.
- Drives the write/read strobes and row/beat indices consumed by the RHS buffer, the PE array and the output buffer.
- Holds the weight-stationary and output-stationary state between jobs.

Parameters:
N, 16, matrix dimension; PE count; rows per LHS job; power of two, at least 4
DELAY, $clog2(N)+2, PE latency in cycles from an LHS row entering the PE to its result row being valid
BEATS, N/4, RHS-load and output-drain beats (4 rows per beat)
BW, max(1,$clog2(BEATS)), beat index width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
rhs_start  in  1  first RHS beat present this cycle
rhs_ready  out  1  RHS load may start
lhs_start  in  1  LHS row 0 present this cycle
lhs_ws  in  1  sampled with lhs_start: keep RHS for the next job
lhs_os  in  1  sampled with lhs_start: accumulate into the pending output
lhs_ready_ns  out  1  plain job accepted
lhs_ready_ws  out  1  ws job accepted
lhs_ready_os  out  1  os job accepted
lhs_ready_wos  out  1  ws+os job accepted
out_start  in  1  first output beat taken this cycle
out_ready  out  1  output drain may start
rhs_wr_en  out  1  write RHS beat into buffer
rhs_beat  out  BW  RHS beat index
pe_issue  out  1  LHS row valid into PEs
pe_row  out  $clog2(N)  LHS row index
cap_en  out  1  write PE result row into output buffer
cap_row  out  $clog2(N)  output row index
cap_acc  out  1  add to existing row instead of overwrite
out_rd_en  out  1  output beat driven
out_beat  out  BW  output beat index
proto_err  out  1  one-cycle pulse: a start was dropped

Behaviour:
- States: IDLE, LOAD, COMPUTE, DRAIN. Flags: rhs_valid, out_pending, job_ws, job_os.
- Reset: state IDLE; all flags 0; every output 0.
- Readies are decoded from registered state only, and are all 0 outside IDLE:
  - rhs_ready = IDLE & !rhs_valid
  - out_ready = IDLE & out_pending
  - lhs_ready_ns = lhs_ready_ws = IDLE & rhs_valid & !out_pending
  - lhs_ready_os = lhs_ready_wos = IDLE & rhs_valid & out_pending
- A start is accepted only while its ready is high. lhs_start is accepted when the ready matching {lhs_ws,lhs_os} is high.
- Same-cycle starts: priority out > rhs > lhs. A start that is dropped (not ready, or lost to priority) pulses proto_err the next cycle and changes no state.
- LOAD, accepted at t0:
  - rhs_wr_en = 1 for t0..t0+BEATS-1; rhs_beat = t-t0. The t0 strobe is combinational from rhs_start.
  - State is IDLE at t0+BEATS with rhs_valid = 1.
  - When BEATS = 1, LOAD is never entered.
- COMPUTE, accepted at t0:
  - job_ws/job_os are latched at t0.
  - pe_issue = 1 for t0..t0+N-1; pe_row = t-t0. The t0 strobe is combinational.
  - cap_en = 1 for t0+DELAY..t0+DELAY+N-1; cap_row = t-t0-DELAY; cap_acc = job_os.
  - State is IDLE at t0+DELAY+N with out_pending = 1 and rhs_valid = job_ws.
- DRAIN, accepted at t0:
  - out_rd_en = 1 for t0..t0+BEATS-1; out_beat = t-t0. The t0 strobe is combinational.
  - State is IDLE at t0+BEATS with out_pending = 0.
- Starts arriving outside IDLE are dropped and flagged via proto_err.
- Counters saturate at their terminal value. No wrap-around reaches the outputs.
- Reset mid-job aborts immediately: strobes are 0 in the next cycle and held buffer contents are treated as invalid via the cleared flags.

Test Plan:
- N=16. rhs_start at cycle 0 -> rhs_wr_en cycles 0-3 with beats 0,1,2,3; rhs_ready=0 cycles 1-4; lhs_ready_ns=1 at cycle 4.
- lhs_start (ns) at cycle 10 -> pe_issue 10-25 with rows 0-15; cap_en 16-31 with cap_acc=0; out_ready=1 and rhs_ready=1 at cycle 32.
- ws job then os job without draining -> after the first job rhs_valid stays 1 and lhs_ready_os=1; the second job has cap_acc=1 on all 16 capture cycles; out_pending stays 1.
- out_start at IDLE with out_pending=1 -> out_rd_en 4 cycles with beats 0-3; then out_ready=0 and lhs_ready_ns reflects rhs_valid.
- out_start and lhs_start (os) in the same cycle -> drain runs, LHS job dropped, proto_err=1 the next cycle; lhs_start during COMPUTE -> proto_err pulse, timing unchanged.
- reset asserted at pe_row=7 -> all strobes 0 next cycle; rhs_ready=1 and out_ready=0 after reset release.

Source files
------------

// File: rtl/spmm_job_sched.sv
// spmm_job_sched: job lifecycle sequencer (RHS load, LHS issue, PE capture, output drain) for the SpMM tile engine
module spmm_job_sched #(
  parameter int N = 16,
  parameter int DELAY = $clog2(N) + 2,
  parameter int BEATS = N / 4,
  parameter int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rhs_start,
  output logic                 rhs_ready,
  input  logic                 lhs_start,
  input  logic                 lhs_ws,
  input  logic                 lhs_os,
  output logic                 lhs_ready_ns,
  output logic                 lhs_ready_ws,
  output logic                 lhs_ready_os,
  output logic                 lhs_ready_wos,
  input  logic                 out_start,
  output logic                 out_ready,
  output logic                 rhs_wr_en,
  output logic [BW-1:0]        rhs_beat,
  output logic                 pe_issue,
  output logic [$clog2(N)-1:0] pe_row,
  output logic                 cap_en,
  output logic [$clog2(N)-1:0] cap_row,
  output logic                 cap_acc,
  output logic                 out_rd_en,
  output logic [BW-1:0]        out_beat,
  output logic                 proto_err
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(DELAY + N + 1);
  localparam logic [CW-1:0] C_BEAT_END = CW'(BEATS - 1);
  localparam logic [CW-1:0] C_JOB_END = CW'(DELAY + N - 1);
  localparam logic [CW-1:0] C_N = CW'(N);
  localparam logic [CW-1:0] C_DELAY = CW'(DELAY);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic rhs_valid, out_pending, job_ws, job_os, err_q;
  logic idle, lhs_sel_ready, acc_out, acc_rhs, acc_lhs, drop, last;
  logic in_load, in_comp, in_drain;
  assign idle = (state == IDLE) && !reset;
  assign in_load = (state == LOAD) && !reset;
  assign in_comp = (state == COMPUTE) && !reset;
  assign in_drain = (state == DRAIN) && !reset;
  assign rhs_ready = idle && !rhs_valid;
  assign out_ready = idle && out_pending;
  assign lhs_ready_ns = idle && rhs_valid && !out_pending;
  assign lhs_ready_ws = lhs_ready_ns;
  assign lhs_ready_os = idle && rhs_valid && out_pending;
  assign lhs_ready_wos = lhs_ready_os;
  assign lhs_sel_ready = idle && rhs_valid && (lhs_os == out_pending);
  assign acc_out = out_start && out_ready;
  assign acc_rhs = rhs_start && rhs_ready && !acc_out;
  assign acc_lhs = lhs_start && lhs_sel_ready && !acc_out && !acc_rhs;
  assign drop = !reset && ((out_start && !acc_out) || (rhs_start && !acc_rhs) || (lhs_start && !acc_lhs));
  assign last = (state == COMPUTE) ? (cnt == C_JOB_END) : (state != IDLE) && (cnt == C_BEAT_END);
  assign rhs_wr_en = acc_rhs || in_load;
  assign rhs_beat = in_load ? BW'(cnt) : '0;
  assign pe_issue = acc_lhs || (in_comp && cnt < C_N);
  assign pe_row = (in_comp && cnt < C_N) ? RW'(cnt) : '0;
  assign cap_en = in_comp && cnt >= C_DELAY;
  assign cap_row = cap_en ? RW'(cnt - C_DELAY) : '0;
  assign cap_acc = cap_en && job_os;
  assign out_rd_en = acc_out || in_drain;
  assign out_beat = in_drain ? BW'(cnt) : '0;
  assign proto_err = err_q && !reset;
  // next state and phase counter; single-beat loads/drains finish in IDLE without leaving it
  always_comb begin
    state_nx = state;
    cnt_nx = (cnt == C_JOB_END) ? cnt : cnt + 1'b1;
    if (state == IDLE) begin
      cnt_nx = CW'(1);
      state_nx = (acc_out && BEATS > 1) ? DRAIN : (acc_rhs && BEATS > 1) ? LOAD : acc_lhs ? COMPUTE : IDLE;
    end else if (last) begin
      state_nx = IDLE;
      cnt_nx = '0;
    end
  end
  // state register, buffer-validity flags, job mode latch and dropped-start pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rhs_valid <= 1'b0;
      out_pending <= 1'b0;
      job_ws <= 1'b0;
      job_os <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      err_q <= drop;
      if (acc_lhs) begin
        job_ws <= lhs_ws;
        job_os <= lhs_os;
      end
      if ((acc_rhs && BEATS == 1) || (state == LOAD && last)) rhs_valid <= 1'b1;
      if (state == COMPUTE && last) begin
        rhs_valid <= job_ws;
        out_pending <= 1'b1;
      end
      if ((acc_out && BEATS == 1) || (state == DRAIN && last)) out_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spmm_job_sched.sv
// tb_spmm_job_sched: scoreboard bench comparing spmm_job_sched against a job-level reference model
module tb_spmm_job_sched;
  localparam int N = 16;
  localparam int DELAY = $clog2(N) + 2;
  localparam int BEATS = N / 4;
  localparam int BW = 2;
  localparam int RW = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rhs_start = 1'b0, lhs_start = 1'b0, lhs_ws = 1'b0, lhs_os = 1'b0, out_start = 1'b0;
  logic rhs_ready, lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos, out_ready;
  logic rhs_wr_en, pe_issue, cap_en, cap_acc, out_rd_en, proto_err;
  logic [BW-1:0] rhs_beat, out_beat;
  logic [RW-1:0] pe_row, cap_row;
  typedef struct {int cyc; int val;} ev_t;
  ev_t q[6][$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_until = 0;
  bit running = 1'b0;
  bit m_rv = 1'b0;
  bit m_op = 1'b0;
  string names[6] = '{"ready", "rhs_wr", "pe_issue", "cap_en", "out_rd", "proto_err"};

  spmm_job_sched #(.N(N)) dut (
    .clock(clock), .reset(reset),
    .rhs_start(rhs_start), .rhs_ready(rhs_ready),
    .lhs_start(lhs_start), .lhs_ws(lhs_ws), .lhs_os(lhs_os),
    .lhs_ready_ns(lhs_ready_ns), .lhs_ready_ws(lhs_ready_ws),
    .lhs_ready_os(lhs_ready_os), .lhs_ready_wos(lhs_ready_wos),
    .out_start(out_start), .out_ready(out_ready),
    .rhs_wr_en(rhs_wr_en), .rhs_beat(rhs_beat),
    .pe_issue(pe_issue), .pe_row(pe_row),
    .cap_en(cap_en), .cap_row(cap_row), .cap_acc(cap_acc),
    .out_rd_en(out_rd_en), .out_beat(out_beat),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // one cycle of stimulus; the model turns each accepted job into its full list of future strobes
  task automatic step(input bit r, input bit rs, input bit ls, input bit ws, input bit os, input bit ost);
    bit idle, ou, rh, lh;
    logic [5:0] e;
    reset = r; rhs_start = rs; lhs_start = ls; lhs_ws = ws; lhs_os = os; out_start = ost;
    running = 1'b1;
    if (r) begin
      for (int k = 1; k < 6; k++) q[k].delete();
      m_rv = 1'b0;
      m_op = 1'b0;
      busy_until = cyc + 1;
      q[0].push_back('{cyc, 0});
    end else begin
      idle = cyc >= busy_until;
      e = idle ? {!m_rv, m_op, m_rv & !m_op, m_rv & !m_op, m_rv & m_op, m_rv & m_op} : 6'd0;
      q[0].push_back('{cyc, int'(e)});
      ou = idle & ost & m_op;
      rh = idle & rs & !m_rv & !ou;
      lh = idle & ls & m_rv & (os == m_op) & !ou & !rh;
      if ((rs & !rh) | (ls & !lh) | (ost & !ou)) q[5].push_back('{cyc + 1, 0});
      if (rh) begin
        for (int b = 0; b < BEATS; b++) q[1].push_back('{cyc + b, b});
        busy_until = cyc + BEATS;
        m_rv = 1'b1;
      end
      if (ou) begin
        for (int b = 0; b < BEATS; b++) q[4].push_back('{cyc + b, b});
        busy_until = cyc + BEATS;
        m_op = 1'b0;
      end
      if (lh) begin
        for (int i = 0; i < N; i++) q[2].push_back('{cyc + i, i});
        for (int i = 0; i < N; i++) q[3].push_back('{cyc + DELAY + i, (os ? N : 0) + i});
        busy_until = cyc + DELAY + N;
        m_op = 1'b1;
        m_rv = ws;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input int k, input logic s, input int v);
    while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL %s missing: expected val %0d at cycle %0d, got no strobe", names[k], q[k][0].val, q[k][0].cyc);
      void'(q[k].pop_front());
    end
    if (s) begin
      total++;
      if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
        bad++;
        $display("FAIL %s unexpected at cycle %0d: got val %0d, required none", names[k], cyc, v);
      end else begin
        if (q[k][0].val != v) begin
          bad++;
          $display("FAIL %s at cycle %0d: got %0d required %0d", names[k], cyc, v, q[k][0].val);
        end
        void'(q[k].pop_front());
      end
    end else if (q[k].size() > 0 && q[k][0].cyc == cyc) begin
      total++; bad++;
      $display("FAIL %s absent at cycle %0d: got 0 required strobe with val %0d", names[k], cyc, q[k][0].val);
      void'(q[k].pop_front());
    end
  endtask

  // monitor: compares every DUT output against the scoreboard mid-cycle
  always @(negedge clock) begin
    if (running) begin
      chk(0, 1'b1, int'({rhs_ready, out_ready, lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos}));
      chk(1, rhs_wr_en, int'(rhs_beat));
      chk(2, pe_issue, int'(pe_row));
      chk(3, cap_en, int'({cap_acc, cap_row}));
      chk(4, out_rd_en, int'(out_beat));
      chk(5, proto_err, 0);
    end
  end

  initial begin
    @(posedge clock);
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    wait_idle(6);
    step(0, 0, 1, 0, 0, 0);
    wait_idle(DELAY + N + 2);
    step(0, 0, 0, 0, 0, 1);
    wait_idle(5);
    step(0, 1, 0, 0, 0, 0);
    wait_idle(5);
    step(0, 0, 1, 1, 0, 0);
    wait_idle(DELAY + N);
    step(0, 0, 1, 0, 1, 0);
    wait_idle(DELAY + N + 1);
    step(0, 0, 1, 0, 1, 1);
    wait_idle(5);
    step(0, 1, 0, 0, 0, 0);
    wait_idle(4);
    step(0, 0, 1, 0, 0, 0);
    wait_idle(3);
    step(0, 0, 1, 0, 0, 0);
    wait_idle(DELAY + N);
    step(0, 0, 0, 0, 0, 1);
    wait_idle(4);
    step(0, 1, 0, 0, 0, 0);
    wait_idle(4);
    step(0, 0, 1, 1, 0, 0);
    wait_idle(6);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    wait_idle(3);
    repeat (3000) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
    end
    wait_idle(DELAY + N + 4);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (q[k].size() != 0) begin
        bad++;
        $display("FAIL %s leftover: got %0d pending events required 0", names[k], q[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
